// File: rtl/i2s_rx_pkg.sv
// Shared constants, channel encoding and magnitude helper for the I2S receiver
// and its voice-activity detector.
package i2s_rx_pkg;

  localparam int SLOT_BITS = 32;
  localparam int BITCNT_W  = 5;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Sign-extends the low `width` bits of val, then returns |val|. The most
  // negative code maps to 2^(width-1), which still fits for width <= 31.
  function automatic logic [31:0] abs_mag(input logic [31:0] val, input int width);
    logic signed [31:0] ext;
    ext = $signed(val << (32 - width)) >>> (32 - width);
    return ext[31] ? 32'(-ext) : 32'(ext);
  endfunction

endpackage

// File: rtl/i2s_vad_energy.sv
// Windowed mean-magnitude voice-activity detector with hangover. One update per
// left-channel sample; the decision register changes the cycle after the window closes.
module i2s_vad_energy
  import i2s_rx_pkg::*;
#(
  parameter int                  SAMPLE_W   = 24,
  parameter int                  WIN_LOG2   = 8,
  parameter logic [SAMPLE_W-1:0] VAD_THRESH = SAMPLE_W'(24'h000800),
  parameter int                  HANGOVER   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        sample_valid,
  input  logic [31:0] sample,
  output logic        vad_active
);

  localparam int ACC_W  = SAMPLE_W + WIN_LOG2;
  localparam int HANG_W = $clog2(HANGOVER + 2);

  logic [ACC_W-1:0]    acc_reg;
  logic [ACC_W-1:0]    acc_next;
  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [HANG_W-1:0]   hang_cnt_reg;
  logic                vad_reg;
  logic                win_done;
  logic                above_thresh;

  // The window-closing sample is folded in before the mean is taken.
  always_comb begin
    acc_next     = acc_reg + ACC_W'(abs_mag(sample, SAMPLE_W));
    win_done     = (win_cnt_reg == '1);
    above_thresh = (acc_next[ACC_W-1:WIN_LOG2] >= VAD_THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg      <= '0;
      win_cnt_reg  <= '0;
      hang_cnt_reg <= '0;
      vad_reg      <= 1'b0;
    end else if (sample_valid) begin
      win_cnt_reg <= win_cnt_reg + WIN_LOG2'(1);
      if (win_done) begin
        acc_reg <= '0;
        if (above_thresh) begin
          vad_reg      <= 1'b1;
          hang_cnt_reg <= HANG_W'(HANGOVER);
        end else if (hang_cnt_reg != '0) begin
          hang_cnt_reg <= hang_cnt_reg - HANG_W'(1);
        end else begin
          vad_reg <= 1'b0;
        end
      end else begin
        acc_reg <= acc_next;
      end
    end
  end

  assign vad_active = vad_reg;

endmodule

// File: rtl/i2s_rx_vad.sv
// I2S master receiver: generates BCLK/WS, captures Philips-format samples from DIN
// and presents one sign-extended word per slot, with a VAD on the left channel.
module i2s_rx_vad
  import i2s_rx_pkg::*;
#(
  parameter int                  CLK_DIV    = 4,
  parameter int                  SAMPLE_W   = 24,
  parameter int                  WIN_LOG2   = 8,
  parameter logic [SAMPLE_W-1:0] VAD_THRESH = SAMPLE_W'(24'h000800),
  parameter int                  HANGOVER   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        DIN,
  output logic        BCLK,
  output logic        WS,
  output logic [31:0] data,
  output logic        done,
  output logic        chan,
  output logic        vad_active
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]    div_cnt_reg;
  logic                bclk_reg;
  logic                ws_reg;
  logic [BITCNT_W-1:0] bit_cnt_reg;
  logic [SAMPLE_W-1:0] shift_reg;
  logic                cap_pend_reg;
  logic                cap_chan_reg;
  logic [31:0]         data_reg;
  logic                done_reg;
  logic                chan_reg;

  logic                div_wrap;
  logic                rise_evt;
  logic                fall_evt;
  logic                in_capture;
  logic                last_capture;
  logic [31:0]         data_next;

  always_comb begin
    div_wrap     = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    rise_evt     = div_wrap && !bclk_reg;
    fall_evt     = div_wrap && bclk_reg;
    in_capture   = (bit_cnt_reg != '0) && (bit_cnt_reg <= BITCNT_W'(SAMPLE_W));
    last_capture = (bit_cnt_reg == BITCNT_W'(SAMPLE_W));
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sext
      assign data_next[gi] = shift_reg[(gi < SAMPLE_W) ? gi : SAMPLE_W - 1];
    end
  endgenerate

  // The last bit lands in shift_reg on the capture rise; the word is published
  // one cycle later so data/chan/done come out of a single register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      ws_reg       <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      cap_pend_reg <= 1'b0;
      cap_chan_reg <= 1'b0;
      data_reg     <= '0;
      done_reg     <= 1'b0;
      chan_reg     <= 1'b0;
    end else if (!en) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      ws_reg       <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      cap_pend_reg <= 1'b0;
      cap_chan_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      div_cnt_reg  <= div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
      cap_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
      if (div_wrap) begin
        bclk_reg <= !bclk_reg;
      end
      if (fall_evt) begin
        bit_cnt_reg <= bit_cnt_reg + BITCNT_W'(1);
        if (bit_cnt_reg == BITCNT_W'(SLOT_BITS - 1)) begin
          ws_reg <= !ws_reg;
        end
      end
      if (rise_evt && in_capture) begin
        shift_reg <= {shift_reg[SAMPLE_W-2:0], DIN};
      end
      if (rise_evt && last_capture) begin
        cap_pend_reg <= 1'b1;
        cap_chan_reg <= ws_reg;
      end
      if (cap_pend_reg) begin
        data_reg <= data_next;
        chan_reg <= cap_chan_reg;
        done_reg <= 1'b1;
      end
    end
  end

  i2s_vad_energy #(
    .SAMPLE_W   (SAMPLE_W),
    .WIN_LOG2   (WIN_LOG2),
    .VAD_THRESH (VAD_THRESH),
    .HANGOVER   (HANGOVER)
  ) u_vad (
    .clk          (clk),
    .rst          (rst),
    .clr          (!en),
    .sample_valid (done_reg && (chan_reg == CH_LEFT)),
    .sample       (data_reg),
    .vad_active   (vad_active)
  );

  assign BCLK = bclk_reg;
  assign WS   = ws_reg;
  assign data = data_reg;
  assign done = done_reg;
  assign chan = chan_reg;

endmodule

// File: tb/tb_i2s_rx_vad.sv
// Directed bench: one default-parameter receiver for capture/timing, one fast
// small-window instance for the voice-activity detector.
module tb_i2s_rx_vad;

  localparam int CD_A = 4;
  localparam int CD_V = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, din_a, en_v, din_v;
  logic        bclk_a, ws_a, done_a, chan_a, vad_a;
  logic        bclk_v, ws_v, done_v, chan_v, vad_v;
  logic [31:0] data_a, data_v;

  always #5 clk = ~clk;

  i2s_rx_vad dut_a (
    .clk(clk), .rst(rst), .en(en_a), .DIN(din_a),
    .BCLK(bclk_a), .WS(ws_a), .data(data_a), .done(done_a),
    .chan(chan_a), .vad_active(vad_a)
  );

  i2s_rx_vad #(
    .CLK_DIV(CD_V), .WIN_LOG2(2), .VAD_THRESH(24'h001000), .HANGOVER(2)
  ) dut_v (
    .clk(clk), .rst(rst), .en(en_v), .DIN(din_v),
    .BCLK(bclk_v), .WS(ws_v), .data(data_v), .done(done_v),
    .chan(chan_v), .vad_active(vad_v)
  );

  int cyc_count = 0;
  int base_a = 0;
  int base_v = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Event recorders, sampled on the falling clock edge.
  int          done_cnt_a = 0;
  int          last_cyc_a = 0;
  int          first_rise_a = -1;
  logic [31:0] last_data_a = '0;
  logic        last_chan_a = 1'b0;
  int          done_cnt_v = 0;
  logic        vad_pend = 1'b0;
  logic        vad_at_done = 1'b0;
  logic        vad_after = 1'b0;

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a  <= done_cnt_a + 1;
      last_cyc_a  <= cyc_count - base_a;
      last_data_a <= data_a;
      last_chan_a <= chan_a;
    end
    if (bclk_a && first_rise_a < 0) first_rise_a <= cyc_count - base_a;
  end

  always @(negedge clk) begin
    if (vad_pend) vad_after <= vad_v;
    vad_pend <= done_v && !chan_v;
    if (done_v && !chan_v) vad_at_done <= vad_v;
    if (done_v) done_cnt_v <= done_cnt_v + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rel(input int w, input int n);
    while (cyc_count - ((w == 0) ? base_a : base_v) < n) @(negedge clk);
  endtask

  // Drives bits 0..last_b of slot s; bit b is presented right after the falling
  // BCLK that starts it and sampled by the DUT half a BCLK later.
  task automatic drive_slot(input int w, input int s, input logic [23:0] word, input int last_b);
    logic [23:0] tmp;
    int cd;
    cd = (w == 0) ? CD_A : CD_V;
    for (int b = 0; b <= last_b; b++) begin
      wait_rel(w, 2 * cd * (32 * s + b));
      tmp = word >> (24 - b);
      if (w == 0) din_a = (b >= 1 && b <= 24) ? tmp[0] : 1'b0;
      else        din_v = (b >= 1 && b <= 24) ? tmp[0] : 1'b0;
    end
  endtask

  logic [23:0] lw [20];
  logic        exp_before [5];
  logic        exp_after [5];
  int          idle_bad;

  initial begin
    rst = 1'b1; en_a = 1'b0; en_v = 1'b0; din_a = 1'b0; din_v = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl_a", {27'd0, bclk_a, ws_a, done_a, chan_a, vad_a}, 32'd0);
    check("reset_data_a", data_a, 32'd0);
    check("reset_ctl_v", {27'd0, bclk_v, ws_v, done_v, chan_v, vad_v}, 32'd0);

    rst = 1'b0;
    idle_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({bclk_a, ws_a, done_a, vad_a, bclk_v, ws_v, done_v, vad_v} !== 8'd0 ||
          data_a !== 32'd0 || data_v !== 32'd0) idle_bad++;
    end
    check("idle_50", idle_bad, 0);

    // Left capture of positive full scale, then right capture of negative full scale.
    en_a = 1'b1; base_a = cyc_count;
    drive_slot(0, 0, 24'h7FFFFF, 31);
    check("first_rise_cyc", first_rise_a, 4);
    check("left_done_cnt", done_cnt_a, 1);
    check("left_done_cyc", last_cyc_a, 197);
    check("left_data", last_data_a, 32'h007FFFFF);
    check("left_chan", {31'd0, last_chan_a}, 32'd0);
    wait_rel(0, 255);
    check("ws_before_fall32", {31'd0, ws_a}, 32'd0);
    wait_rel(0, 256);
    check("ws_after_fall32", {31'd0, ws_a}, 32'd1);
    drive_slot(0, 1, 24'h800000, 31);
    wait_rel(0, 512);
    check("right_done_cnt", done_cnt_a, 2);
    check("right_done_cyc", last_cyc_a, 453);
    check("right_data", last_data_a, 32'hFF800000);
    check("right_chan", {31'd0, last_chan_a}, 32'd1);

    // Drop enable at bit_cnt=10 of a left slot while BCLK is high.
    drive_slot(0, 2, 24'hFFFFFF, 10);
    wait_rel(0, 597);
    check("endrop_pre_bclk", {31'd0, bclk_a}, 32'd1);
    en_a = 1'b0;
    @(negedge clk);
    check("endrop_bclk", {31'd0, bclk_a}, 32'd0);
    check("endrop_ws", {31'd0, ws_a}, 32'd0);
    repeat (300) @(negedge clk);
    check("endrop_no_done", done_cnt_a, 2);
    check("idle_hold_data", data_a, 32'hFF800000);

    en_a = 1'b1; base_a = cyc_count;
    drive_slot(0, 0, 24'h123456, 31);
    check("reen_done_cnt", done_cnt_a, 3);
    check("reen_done_cyc", last_cyc_a, 197);
    check("reen_data", last_data_a, 32'h00123456);
    check("reen_chan", {31'd0, last_chan_a}, 32'd0);

    // Reset pulse in the middle of a right slot with enable held high.
    drive_slot(0, 1, 24'h7FFFFF, 12);
    wait_rel(0, 357);
    check("rst_pre_bclk_ws", {30'd0, bclk_a, ws_a}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ctl", {27'd0, bclk_a, ws_a, done_a, chan_a, vad_a}, 32'd0);
    check("rst_data", data_a, 32'd0);
    rst = 1'b0; base_a = cyc_count;
    drive_slot(0, 0, 24'hA5A5A5, 31);
    check("rst_resume_cnt", done_cnt_a, 4);
    check("rst_resume_cyc", last_cyc_a, 197);
    check("rst_resume_data", last_data_a, 32'hFFA5A5A5);
    check("rst_resume_chan", {31'd0, last_chan_a}, 32'd0);

    // VAD: one loud window, three silent windows, then a window exactly at threshold.
    lw = '{24'h002000, 24'hFFE000, 24'h002000, 24'hFFE000,
           24'h0, 24'h0, 24'h0, 24'h0,
           24'h0, 24'h0, 24'h0, 24'h0,
           24'h0, 24'h0, 24'h0, 24'h0,
           24'h001000, 24'h001000, 24'h001000, 24'h001000};
    exp_before = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_after  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    en_v = 1'b1; base_v = cyc_count;
    for (int k = 0; k < 20; k++) begin
      drive_slot(1, 2 * k, lw[k], 31);
      drive_slot(1, 2 * k + 1, 24'h7FFFFF, 31);
      if (k == 2) check("vad_before_window", {31'd0, vad_v}, 32'd0);
      if (k % 4 == 3) begin
        check($sformatf("vad_w%0d_at_done", k / 4), {31'd0, vad_at_done}, {31'd0, exp_before[k / 4]});
        check($sformatf("vad_w%0d_after", k / 4), {31'd0, vad_after}, {31'd0, exp_after[k / 4]});
      end
    end
    wait_rel(1, 4 * 32 * 40 + 8);
    check("vad_done_cnt", done_cnt_v, 40);
    check("vad_right_data", data_v, 32'h007FFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
